// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the doubleword data-memory responder.
// Holds the FSM encoding, parameter defaults and address-bound helpers.
package mem_resp_pkg;

  localparam int DEPTH_DEFAULT   = 64;
  localparam int LATENCY_DEFAULT = 2;
  localparam int DATA_W          = 64;
  localparam int ADDR_W          = 64;
  localparam int OFS_W           = 3;   // byte offset bits inside a doubleword
  localparam int CNT_W           = 4;   // wide enough for LATENCY-1 up to 14

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // First byte address past the end of storage.
  function automatic logic [ADDR_W-1:0] addr_limit(input int depth);
    return ADDR_W'(depth) << OFS_W;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data-memory responder.
// A request transfers on a rising edge with req_valid && req_ready; a response
// transfers on a rising edge with resp_valid && resp_ready, and the responder
// holds resp_* stable until that edge.
interface data_mem_responder_if;
  import mem_resp_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Doubleword storage: synchronous write, combinational read, synchronous clear.
// Clear has priority over a write on the same edge.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Accepts one request in IDLE, counts down in WAIT, presents a registered response in RESP.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output state_e               state_dbg
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT    = addr_limit(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

  state_e            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              resp_valid_q, resp_valid_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic              err_q, err_n;
  logic              acc_err;
  logic              mem_we;
  logic              mem_clear;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;

  assign acc_err   = (addr_q[OFS_W-1:0] != '0) || (addr_q >= LIMIT);
  assign idx       = addr_q[IDX_W+OFS_W-1:OFS_W];
  assign mem_clear = ~reset;

  mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .clear (mem_clear),
    .we    (mem_we),
    .idx   (idx),
    .wdata (wdata_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    wr_n         = wr_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    resp_valid_n = resp_valid_q;
    rdata_n      = rdata_q;
    err_n        = err_q;
    mem_we       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          wr_n    = bus.req_write;
          addr_n  = bus.req_addr;
          wdata_n = bus.req_wdata;
          cnt_n   = CNT_LOAD;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          // The access and the response capture happen on the same edge.
          mem_we       = wr_q && !acc_err;
          resp_valid_n = 1'b1;
          rdata_n      = (wr_q || acc_err) ? '0 : rd_data;
          err_n        = acc_err;
          state_n      = RESP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_n = 1'b0;
          rdata_n      = '0;
          err_n        = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      wr_q         <= wr_n;
      addr_q       <= addr_n;
      wdata_q      <= wdata_n;
      resp_valid_q <= resp_valid_n;
      rdata_q      <= rdata_n;
      err_q        <= err_n;
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: scoreboard queue filled by the driver,
// drained by an independent response monitor; a second instance runs with LATENCY = 1.
module tb_data_mem_responder;
  import mem_resp_pkg::*;

  localparam int LAT0 = 2;
  localparam logic [63:0] PAT = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();
  state_e st0, st1;

  data_mem_responder #(.DEPTH(64), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .state_dbg(st0)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .state_dbg(st1)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [64:0] exp_q[$];
  int acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Response monitor for instance 0.
  initial begin : monitor
    logic        in_resp;
    logic [64:0] held;
    logic [64:0] cur;
    in_resp = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      cur = {bus0.resp_err, bus0.resp_rdata};
      if (!bus0.resp_valid) begin
        in_resp = 1'b0;
        if (cyc > 0) chk("idle_outputs_zero", cur, 65'd0);
      end else begin
        if (!in_resp) begin
          in_resp = 1'b1;
          held = cur;
          if (acc_q.size() == 0) flag("unexpected_response");
          else chk("latency", 65'(cyc - acc_q.pop_front()), 65'(LAT0));
        end else begin
          chk("resp_stable", cur, held);
        end
        if (bus0.resp_ready) begin
          in_resp = 1'b0;
          if (exp_q.size() == 0) flag("response_without_expectation");
          else chk("resp_data", cur, exp_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic exp_err, input logic [63:0] exp_rdata, input logic track);
    int n;
    n = 0;
    while (!bus0.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus0.req_ready) begin
      flag("req_ready_timeout");
      return;
    end
    bus0.req_valid = 1'b1;
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    if (track) exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk); #1;
    if (track) acc_q.push_back(cyc);
    bus0.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus0.resp_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || bus0.resp_valid) flag("drain_timeout");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.resp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
    bus1.resp_ready = 1'b1;

    // Reset held for two edges.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("reset_req_ready", {64'd0, bus0.req_ready}, 65'd1);
    chk("reset_resp_valid", {64'd0, bus0.resp_valid}, 65'd0);
    chk("reset_state", {63'd0, st0}, {63'd0, IDLE});
    issue(1'b0, 64'h10, '0, 1'b0, 64'd0, 1'b1);
    drain();

    // Store then load.
    issue(1'b1, 64'h08, PAT, 1'b0, 64'd0, 1'b1);
    issue(1'b0, 64'h08, '0, 1'b0, PAT, 1'b1);
    issue(1'b1, 64'h1F8, 64'hA5A5, 1'b0, 64'd0, 1'b1);
    drain();

    // Misaligned and out-of-range accesses must not touch storage.
    issue(1'b1, 64'h0C, 64'h1111, 1'b1, 64'd0, 1'b1);
    issue(1'b1, 64'h200, 64'h1111, 1'b1, 64'd0, 1'b1);
    issue(1'b0, 64'h200, '0, 1'b1, 64'd0, 1'b1);
    issue(1'b0, 64'h0C, '0, 1'b1, 64'd0, 1'b1);
    issue(1'b0, 64'h08, '0, 1'b0, PAT, 1'b1);
    issue(1'b0, 64'h1F8, '0, 1'b0, 64'hA5A5, 1'b1);
    issue(1'b0, 64'h00, '0, 1'b0, 64'd0, 1'b1);
    drain();

    // Backpressure with a competing request held on the bus.
    bus0.resp_ready = 1'b0;
    issue(1'b0, 64'h1F8, '0, 1'b0, 64'hA5A5, 1'b1);
    n = 0;
    while (!bus0.resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus0.resp_valid) flag("bp_resp_timeout");
    bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = 64'h08;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_req_ready_low", {64'd0, bus0.req_ready}, 65'd0);
      chk("bp_resp_valid_held", {64'd0, bus0.resp_valid}, 65'd1);
    end
    exp_q.push_back({1'b0, PAT});
    bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_req_ready", {64'd0, bus0.req_ready}, 65'd1);
    chk("bp_release_resp_valid", {64'd0, bus0.resp_valid}, 65'd0);
    @(posedge clk); #1;
    acc_q.push_back(cyc);
    bus0.req_valid = 1'b0;
    drain();

    // Reset while a store is in WAIT.
    issue(1'b1, 64'h18, 64'h55, 1'b0, 64'd0, 1'b0);
    chk("midrst_in_wait", {63'd0, st0}, {63'd0, WAIT});
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midrst_state_idle", {63'd0, st0}, {63'd0, IDLE});
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_response", {64'd0, bus0.resp_valid}, 65'd0);
    issue(1'b0, 64'h18, '0, 1'b0, 64'd0, 1'b1);
    issue(1'b0, 64'h08, '0, 1'b0, 64'd0, 1'b1);
    drain();

    // LATENCY = 1 instance: response right after the edge following acceptance.
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_addr = 64'h20; bus1.req_wdata = 64'h77;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("l1_store_not_yet", {64'd0, bus1.resp_valid}, 65'd0);
    @(posedge clk); #1;
    chk("l1_store_valid", {64'd0, bus1.resp_valid}, 65'd1);
    chk("l1_store_resp", {bus1.resp_err, bus1.resp_rdata}, 65'd0);
    @(posedge clk); #1;
    chk("l1_store_idle", {64'd0, bus1.req_ready}, 65'd1);
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 64'h20;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("l1_load_not_yet", {64'd0, bus1.resp_valid}, 65'd0);
    @(posedge clk); #1;
    chk("l1_load_valid", {64'd0, bus1.resp_valid}, 65'd1);
    chk("l1_load_resp", {bus1.resp_err, bus1.resp_rdata}, {1'b0, 64'h77});
    @(posedge clk); #1;

    if (acc_q.size() != 0) flag("leftover_acceptances");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
